window_frame_sequencer: RTL and testbench
=========================================

# window_frame_sequencer

Frame controller in front of the Hanning window stage of the hard BPM path. It pulls low-pass-filtered samples from the sample FIFO and tags each one with its in-frame index (0..N-1) for the window coefficient lookup. It also marks frame start and end. After each frame it holds off the FIFO until the FFT stage acknowledges that it has consumed the frame.

## Interface
Parameters:
- W, 16, sample width
- N, 1024, frame length in samples, N ≥ 2
- IDX_W, 10, index width, 2^IDX_W ≥ N

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- run  in  1  level; enables frame capture
- abort  in  1  pulse; cancel current frame
- fifo_valid  in  1  FIFO has a sample
- fifo_data  in  W  FIFO sample
- fifo_ready  out  1  sequencer accepts a FIFO sample this cycle
- out_ready  in  1  window stage can accept
- out_valid  out  1  out_sample/out_index valid
- out_sample  out  W  sample to window stage
- out_index  out  IDX_W  in-frame index (coefficient address)
- out_sop  out  1  out_index == 0
- out_eop  out  1  out_index == N-1
- frame_ack  in  1  pulse; FFT stage finished consuming the frame
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse when a frame is acknowledged
- frame_count  out  16  acknowledged frames (see Configuration)

## Operation
- States:
  - IDLE: fifo_ready=0.
  - STREAM: accept N samples.
  - WAIT_ACK: fifo_ready=0; waiting for frame_ack.
- Transitions:
  - IDLE→STREAM when run=1.
  - STREAM→WAIT_ACK on the FIFO transfer of index N-1.
  - WAIT_ACK→STREAM on frame_ack if run=1.
  - WAIT_ACK→IDLE on frame_ack if run=0.
- fifo_ready = (state==STREAM) && (!out_valid || out_ready). This is a combinational function of registered state plus out_ready.
- FIFO transfer (fifo_valid && fifo_ready):
  - register out_sample=fifo_data, out_index=idx, out_sop=(idx==0), out_eop=(idx==N-1);
  - set out_valid=1;
  - idx wraps to 0 after N-1, otherwise idx+1.
- Output transfer (out_valid && out_ready) with no new FIFO transfer in the same cycle: out_valid→0. Output registers hold their values while out_valid && !out_ready.
- Simultaneous output transfer and FIFO transfer: output registers are reloaded and out_valid stays 1.
- run deasserted mid-frame: the frame completes to N-1 and WAIT_ACK is still required. A frame is never truncated by run.
- frame_ack in IDLE or STREAM: ignored.
- frame_ack in WAIT_ACK: frame_done=1 for one cycle and frame_count increments.
- abort (any state, priority below reset): next cycle state=IDLE, idx=0, out_valid=0. No frame_done and no count increment. A partial frame is discarded.
- Samples are never dropped or duplicated. While fifo_ready=0 the FIFO holds its data.

## Timing
- Reset values:
  - state=IDLE, idx=0
  - out_valid=0, out_sample=0, out_index=0, out_sop=0, out_eop=0
  - fifo_ready=0, busy=0, frame_done=0, frame_count=0
- Latency: FIFO transfer at edge k gives out_valid=1 after edge k; one cycle.
- Throughput: one sample per cycle with out_ready held at 1.
- busy rises the cycle after run is sampled high in IDLE.
- frame_done asserts the cycle after frame_ack is sampled in WAIT_ACK. The next frame's first fifo_ready is in that same cycle if run=1.
- Reset or abort mid-frame takes effect at the next edge, regardless of handshakes in flight.

## Configuration
- WINDOW_SEQ_FRAME_COUNT_EN:
  - defined: frame_count is a 16-bit counter of acknowledged frames; it wraps 0xFFFF→0 and is cleared by reset only (not by abort).
  - undefined: frame_count is tied to 0 and no counter register is built.

## Test plan
Use N=8, IDX_W=3, W=16 unless stated.
- Basic frame: run=1, FIFO supplies 0x0001..0x0008 back-to-back, out_ready=1.
  - Response: out_index 0..7 on consecutive cycles; out_sop with 0x0001, out_eop with 0x0008; fifo_ready=0 after the 8th transfer.
  - Then frame_ack → frame_done pulse; frame_count=1 (with WINDOW_SEQ_FRAME_COUNT_EN); fifo_ready=1 the same cycle.
- Backpressure: out_ready low for 3 cycles at index 3.
  - Response: out_sample/out_index held stable, fifo_ready=0 throughout, no sample lost; index 4 follows once out_ready rises.
- run dropped at index 5: frame completes to index 7; after frame_ack, state returns to IDLE (busy=0) and fifo_ready stays 0.
- Abort at index 4: next cycle busy=0, out_valid=0, no frame_done. With run=1 the next frame restarts at out_index=0 (out_sop=1).
- Stray frame_ack in STREAM: no frame_done, frame_count unchanged. Build without the macro: frame_count stays 0 across 3 frames.
- Reset asserted mid-frame with out_valid=1: all outputs are at their reset values the next cycle.

Source files
------------

// File: rtl/window_frame_sequencer.sv
// Frame sequencer ahead of the Hanning window stage: tags FIFO samples with in-frame index,
// marks SOP/EOP and holds off the FIFO until the FFT acknowledges. Optional: WINDOW_SEQ_FRAME_COUNT_EN.
module window_frame_sequencer #(
  parameter int W     = 16,
  parameter int N     = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             abort,
  input  logic             fifo_valid,
  input  logic [W-1:0]     fifo_data,
  output logic             fifo_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_sample,
  output logic [IDX_W-1:0] out_index,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             frame_ack,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_ACK} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             xfer;

  assign fifo_ready = (state == STREAM) && (!out_valid || out_ready);
  assign xfer       = fifo_valid && fifo_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_index  <= '0;
      out_sop    <= 1'b0;
      out_eop    <= 1'b0;
      frame_done <= 1'b0;
    end else if (abort) begin
      // Partial frame is dropped; last output payload is left as-is but invalidated.
      state      <= IDLE;
      idx        <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        out_sample <= fifo_data;
        out_index  <= idx;
        out_sop    <= (idx == '0);
        out_eop    <= (idx == LAST);
        out_valid  <= 1'b1;
        idx        <= (idx == LAST) ? '0 : idx + IDX_W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE:     if (run) state <= STREAM;
        STREAM:   if (xfer && idx == LAST) state <= WAIT_ACK;
        WAIT_ACK: if (frame_ack) begin
          frame_done <= 1'b1;
          state      <= run ? STREAM : IDLE;
        end
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef WINDOW_SEQ_FRAME_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (!abort && state == WAIT_ACK && frame_ack) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_window_frame_sequencer.sv
// Randomized bench for window_frame_sequencer (N=8) against a frame-level reference model.
module tb_window_frame_sequencer;

  localparam int W     = 16;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             reset, run, abort, fifo_valid, out_ready, frame_ack;
  logic [W-1:0]     fifo_data;
  logic             fifo_ready, out_valid, out_sop, out_eop, busy, frame_done;
  logic [W-1:0]     out_sample;
  logic [IDX_W-1:0] out_index;
  logic [15:0]      frame_count;

  window_frame_sequencer #(.W(W), .N(N), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort),
    .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_sample(out_sample),
    .out_index(out_index), .out_sop(out_sop), .out_eop(out_eop),
    .frame_ack(frame_ack), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is either not started, being filled (pos samples so far),
  // or complete and awaiting acknowledgement. Output is a one-deep holding slot.
  bit          in_frame, awaiting, fd_m, ov_m, fresh_m;
  int          pos_m, oi_m;
  logic [15:0] os_m;
  int unsigned acks_m;
  logic [15:0] next_data;

  task automatic model_reset();
    in_frame = 0; awaiting = 0; fd_m = 0; ov_m = 0; fresh_m = 1;
    pos_m = 0; oi_m = 0; os_m = '0; acks_m = 0;
  endtask

  initial begin
    bit exp_ready, got_xfer;
    bit was_idle, was_stream, was_wait;
    logic [15:0] exp_cnt;

    reset = 1; run = 0; abort = 0; fifo_valid = 0; out_ready = 0; frame_ack = 0;
    next_data = 16'h0001; fifo_data = next_data;
    model_reset();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 3) begin
        reset = 1; run = 0; abort = 0; fifo_valid = 0; out_ready = 0; frame_ack = 0;
      end else if (cyc < 16) begin
        // clean first frame: back-to-back samples, sink always ready, ack after it ends
        reset = 0; run = 1; abort = 0; fifo_valid = 1; out_ready = 1;
        frame_ack = (cyc == 14);
      end else begin
        reset      = ($urandom_range(0, 499) == 0);
        abort      = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 39) == 0) run = ~run;
        fifo_valid = ($urandom_range(0, 9) < 8);
        out_ready  = ($urandom_range(0, 3) != 0);
        frame_ack  = ($urandom_range(0, 5) == 0);
      end
      fifo_data = next_data;

      #1;
      exp_ready = in_frame && !awaiting && (!ov_m || out_ready);
`ifdef WINDOW_SEQ_FRAME_COUNT_EN
      exp_cnt = 16'(acks_m);
`else
      exp_cnt = 16'd0;
`endif
      check_eq("fifo_ready", 32'(fifo_ready), 32'(exp_ready));
      check_eq("busy", 32'(busy), 32'(in_frame));
      check_eq("out_valid", 32'(out_valid), 32'(ov_m));
      check_eq("frame_done", 32'(frame_done), 32'(fd_m));
      check_eq("frame_count", 32'(frame_count), 32'(exp_cnt));
      if (ov_m || fresh_m) begin
        check_eq("out_sample", 32'(out_sample), 32'(os_m));
        check_eq("out_index", 32'(out_index), 32'(oi_m));
        check_eq("out_sop", 32'(out_sop), 32'(ov_m && oi_m == 0));
        check_eq("out_eop", 32'(out_eop), 32'(ov_m && oi_m == N - 1));
      end

      @(posedge clk);
      was_idle   = !in_frame;
      was_stream = in_frame && !awaiting;
      was_wait   = in_frame && awaiting;
      got_xfer   = fifo_valid && exp_ready;
      if (reset) begin
        model_reset();
      end else if (abort) begin
        in_frame = 0; awaiting = 0; pos_m = 0; ov_m = 0; fd_m = 0;
      end else begin
        fd_m = 0;
        if (got_xfer) begin
          os_m = fifo_data; oi_m = pos_m; ov_m = 1; fresh_m = 0;
          pos_m = (pos_m + 1) % N;
          if (pos_m == 0) awaiting = 1;
        end else if (ov_m && out_ready) begin
          ov_m = 0;
        end
        if (was_idle && run) in_frame = 1;
        if (was_wait && frame_ack) begin
          fd_m = 1; acks_m = (acks_m + 1) % 65536;
          awaiting = 0; in_frame = run;
        end
      end
      // ignore was_stream: stray acks have no effect while filling
      if (was_stream) begin end
      if (got_xfer) next_data = (cyc < 16) ? next_data + 16'd1 : 16'($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
